// File: rtl/tlbr_exc_unit_pkg.sv
// Shared definitions for the TLB-refill exception unit: CSR field positions,
// FSM state encoding and the CRMD values used on handler entry and return.
package tlbr_exc_unit_pkg;

  localparam int TLBRERA_ISTLBR = 0;
  localparam int VPPN_LSB       = 13;
  localparam int ENTRY_ALIGN    = 6;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ENTER     = 2'd1;
  localparam logic [1:0] ST_INHANDLER = 2'd2;
  localparam logic [1:0] ST_LEAVE     = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    ENTER     = ST_ENTER,
    INHANDLER = ST_INHANDLER,
    LEAVE     = ST_LEAVE
  } state_e;

  // CRMD image on refill entry (direct address, interrupts off) and on ERTN
  localparam logic CRMD_IE_HANDLER = 1'b0;
  localparam logic CRMD_DA_HANDLER = 1'b1;
  localparam logic CRMD_PG_HANDLER = 1'b0;
  localparam logic CRMD_DA_RETURN  = 1'b0;
  localparam logic CRMD_PG_RETURN  = 1'b1;

  function automatic logic [31:0] era_pack(input logic [29:0] pc_hi, input logic is_tlbr);
    return {pc_hi, 1'b0, is_tlbr};
  endfunction

endpackage

// File: rtl/tlbr_save_regs.sv
// Saved-state registers for a TLB refill: return PC with IsTLBR flag, bad
// address, VPPN and previous CRMD. Capture beats the IsTLBR clear beats a CSR write.
module tlbr_save_regs
  import tlbr_exc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        clear_istlbr,
  input  logic        csr_wr_en,
  input  logic [31:0] csr_wr_data,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_badv,
  input  logic [1:0]  crmd_plv,
  input  logic        crmd_ie,
  output logic [31:0] era,
  output logic [31:0] badv,
  output logic [18:0] vppn,
  output logic [2:0]  prmd
);

  logic [29:0] era_pc;
  logic        is_tlbr;

  // low PC bits and the hardwired-zero ERA bit are never stored
  logic unused_bits;
  assign unused_bits = ^{commit_pc[1:0], csr_wr_data[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      era_pc  <= '0;
      is_tlbr <= 1'b0;
      badv    <= '0;
      vppn    <= '0;
      prmd    <= '0;
    end else if (capture) begin
      era_pc  <= commit_pc[31:2];
      is_tlbr <= 1'b1;
      badv    <= commit_badv;
      vppn    <= commit_badv[31:VPPN_LSB];
      prmd    <= {crmd_ie, crmd_plv};
    end else if (clear_istlbr) begin
      is_tlbr <= 1'b0;
    end else if (csr_wr_en) begin
      era_pc  <= csr_wr_data[31:2];
      is_tlbr <= csr_wr_data[TLBRERA_ISTLBR];
    end
  end

  assign era = era_pack(era_pc, is_tlbr);

endmodule

// File: rtl/tlbr_exc_unit.sv
// TLB-refill exception sequencer: saves state on a refill, redirects fetch to
// TLBRENTRY, and on ERTN restores CRMD and returns to the saved PC.
//
//   state     | meaning
//   IDLE      | no refill in progress
//   ENTER     | one cycle: flush, redirect to TLBRENTRY, CRMD to handler mode
//   INHANDLER | refill handler running; waits for ERTN or a nested refill
//   LEAVE     | one cycle: flush, redirect to saved PC, CRMD restored
module tlbr_exc_unit
  import tlbr_exc_unit_pkg::*;
#(
  parameter logic [1:0] RESET_PLV = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_tlbr_exc,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_badv,
  input  logic        commit_ertn,
  input  logic [31:0] TLBRENTRY,
  input  logic [1:0]  crmd_plv,
  input  logic        crmd_ie,
  input  logic        CSRWR_TLBRERA_en,
  input  logic [31:0] CSRWR_TLBRERA_data,
  output logic [31:0] TLBRERA,
  output logic [31:0] TLBRBADV,
  output logic [18:0] TLBREHI_VPPN,
  output logic [2:0]  TLBRPRMD,
  output logic        crmd_wr_en,
  output logic [1:0]  crmd_wr_plv,
  output logic        crmd_wr_ie,
  output logic        crmd_wr_da,
  output logic        crmd_wr_pg,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  state_e state, state_next;
  logic   capture;
  logic   clear_istlbr;

  logic unused_entry_bits;
  assign unused_entry_bits = ^TLBRENTRY[ENTRY_ALIGN-1:0];

  // commit is flushed during ENTER/LEAVE, so pulses there are not accepted
  assign capture      = commit_tlbr_exc && (state == IDLE || state == INHANDLER);
  assign clear_istlbr = (state == LEAVE);

  tlbr_save_regs u_save_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture),
    .clear_istlbr (clear_istlbr),
    .csr_wr_en    (CSRWR_TLBRERA_en),
    .csr_wr_data  (CSRWR_TLBRERA_data),
    .commit_pc    (commit_pc),
    .commit_badv  (commit_badv),
    .crmd_plv     (crmd_plv),
    .crmd_ie      (crmd_ie),
    .era          (TLBRERA),
    .badv         (TLBRBADV),
    .vppn         (TLBREHI_VPPN),
    .prmd         (TLBRPRMD)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (commit_tlbr_exc) state_next = ENTER;
      end
      ENTER: begin
        state_next = INHANDLER;
      end
      INHANDLER: begin
        if (commit_tlbr_exc)  state_next = ENTER;
        else if (commit_ertn) state_next = LEAVE;
      end
      LEAVE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    crmd_wr_en     = 1'b0;
    crmd_wr_plv    = RESET_PLV;
    crmd_wr_ie     = 1'b0;
    crmd_wr_da     = 1'b0;
    crmd_wr_pg     = 1'b0;
    unique case (state)
      ENTER: begin
        redirect_valid = 1'b1;
        redirect_pc    = {TLBRENTRY[31:ENTRY_ALIGN], {ENTRY_ALIGN{1'b0}}};
        flush          = 1'b1;
        crmd_wr_en     = 1'b1;
        crmd_wr_plv    = RESET_PLV;
        crmd_wr_ie     = CRMD_IE_HANDLER;
        crmd_wr_da     = CRMD_DA_HANDLER;
        crmd_wr_pg     = CRMD_PG_HANDLER;
      end
      LEAVE: begin
        redirect_valid = 1'b1;
        redirect_pc    = {TLBRERA[31:2], 2'b00};
        flush          = 1'b1;
        crmd_wr_en     = 1'b1;
        crmd_wr_plv    = TLBRPRMD[1:0];
        crmd_wr_ie     = TLBRPRMD[2];
        crmd_wr_da     = CRMD_DA_RETURN;
        crmd_wr_pg     = CRMD_PG_RETURN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tlbr_exc_unit.sv
// Scoreboard bench for tlbr_exc_unit: each driven cycle pushes the expected
// output image of the next cycle, popped and compared on the falling edge.
module tb_tlbr_exc_unit;

  logic        clk;
  logic        rst_n;
  logic        commit_tlbr_exc;
  logic [31:0] commit_pc;
  logic [31:0] commit_badv;
  logic        commit_ertn;
  logic [31:0] TLBRENTRY;
  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic        CSRWR_TLBRERA_en;
  logic [31:0] CSRWR_TLBRERA_data;
  logic [31:0] TLBRERA;
  logic [31:0] TLBRBADV;
  logic [18:0] TLBREHI_VPPN;
  logic [2:0]  TLBRPRMD;
  logic        crmd_wr_en;
  logic [1:0]  crmd_wr_plv;
  logic        crmd_wr_ie;
  logic        crmd_wr_da;
  logic        crmd_wr_pg;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic        we;
    logic [1:0]  plv;
    logic        ie;
    logic        da;
    logic        pg;
    logic [31:0] era;
    logic [31:0] badv;
    logic [18:0] vppn;
    logic [2:0]  prmd;
  } exp_t;

  typedef struct packed {
    logic        exc;
    logic        ertn;
    logic [31:0] pc;
    logic [31:0] badv;
    logic [1:0]  plv;
    logic        ie;
    logic        wr;
    logic [31:0] wd;
  } stim_t;

  exp_t sb[$];

  tlbr_exc_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .commit_tlbr_exc    (commit_tlbr_exc),
    .commit_pc          (commit_pc),
    .commit_badv        (commit_badv),
    .commit_ertn        (commit_ertn),
    .TLBRENTRY          (TLBRENTRY),
    .crmd_plv           (crmd_plv),
    .crmd_ie            (crmd_ie),
    .CSRWR_TLBRERA_en   (CSRWR_TLBRERA_en),
    .CSRWR_TLBRERA_data (CSRWR_TLBRERA_data),
    .TLBRERA            (TLBRERA),
    .TLBRBADV           (TLBRBADV),
    .TLBREHI_VPPN       (TLBREHI_VPPN),
    .TLBRPRMD           (TLBRPRMD),
    .crmd_wr_en         (crmd_wr_en),
    .crmd_wr_plv        (crmd_wr_plv),
    .crmd_wr_ie         (crmd_wr_ie),
    .crmd_wr_da         (crmd_wr_da),
    .crmd_wr_pg         (crmd_wr_pg),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .flush              (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t e_idle(input logic [31:0] era, input logic [31:0] badv,
                                  input logic [18:0] vppn, input logic [2:0] prmd);
    return '{1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, era, badv, vppn, prmd};
  endfunction

  function automatic exp_t e_enter(input logic [31:0] entry, input logic [31:0] era,
                                   input logic [31:0] badv, input logic [18:0] vppn,
                                   input logic [2:0] prmd);
    return '{1'b1, {entry[31:6], 6'b0}, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0,
             era, badv, vppn, prmd};
  endfunction

  function automatic exp_t e_leave(input logic [31:0] era, input logic [31:0] badv,
                                   input logic [18:0] vppn, input logic [2:0] prmd);
    return '{1'b1, {era[31:2], 2'b0}, 1'b1, 1'b1, prmd[1:0], prmd[2], 1'b0, 1'b1,
             era, badv, vppn, prmd};
  endfunction

  function automatic stim_t s(input logic exc, input logic ertn, input logic [31:0] pc,
                              input logic [31:0] badv, input logic [1:0] plv, input logic ie,
                              input logic wr, input logic [31:0] wd);
    return '{exc, ertn, pc, badv, plv, ie, wr, wd};
  endfunction

  function automatic exp_t snap();
    return '{redirect_valid, redirect_pc, flush, crmd_wr_en, crmd_wr_plv, crmd_wr_ie,
             crmd_wr_da, crmd_wr_pg, TLBRERA, TLBRBADV, TLBREHI_VPPN, TLBRPRMD};
  endfunction

  task automatic apply(input stim_t st);
    commit_tlbr_exc    = st.exc;
    commit_ertn        = st.ertn;
    commit_pc          = st.pc;
    commit_badv        = st.badv;
    crmd_plv           = st.plv;
    crmd_ie            = st.ie;
    CSRWR_TLBRERA_en   = st.wr;
    CSRWR_TLBRERA_data = st.wd;
  endtask

  function automatic stim_t idle_s();
    return s(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
  endfunction

  // Runs a stimulus table; table entry i produces expectation ex[i] one cycle later.
  task automatic run_table(input string name, input stim_t st[$], input exp_t ex[$]);
    exp_t e, o;
    foreach (st[i]) begin
      @(negedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s[%0d] got %h want %h", name, i, o, e);
        end
      end
      apply(st[i]);
      sb.push_back(ex[i]);
    end
    @(negedge clk); #1;
    e = sb.pop_front(); o = snap(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s[end] got %h want %h", name, o, e);
    end
    apply(idle_s());
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0;
    apply(idle_s());
    TLBRENTRY = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    o = snap(); checks++;
    if (o !== e_idle(32'h0, 32'h0, 19'h0, 3'h0)) begin
      errors++;
      $display("FAIL reset got %h want %h", o, e_idle(32'h0, 32'h0, 19'h0, 3'h0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_refill();
    stim_t st[$];
    exp_t  ex[$];
    TLBRENTRY = 32'h1C00_0040;
    st.push_back(s(1, 0, 32'h8000_1234, 32'h0040_2ABC, 2'd3, 1, 0, 0));
    ex.push_back(e_enter(32'h1C00_0040, 32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    run_table("basic_refill", st, ex);
  endtask

  task automatic test_return();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(s(0, 1, 32'h0, 32'h0, 2'd0, 0, 0, 0));
    ex.push_back(e_leave(32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_1234, 32'h0040_2ABC, 19'h00201, 3'b111));
    run_table("return", st, ex);
  endtask

  task automatic test_stray_ertn();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(s(0, 1, 32'h1111_1110, 32'h2222_2222, 2'd1, 1, 0, 0));
    ex.push_back(e_idle(32'h8000_1234, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(s(0, 1, 32'h3333_3330, 32'h4444_4444, 2'd2, 0, 0, 0));
    ex.push_back(e_idle(32'h8000_1234, 32'h0040_2ABC, 19'h00201, 3'b111));
    run_table("stray_ertn", st, ex);
  endtask

  task automatic test_simultaneous();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(s(1, 0, 32'h8000_1234, 32'h0040_2ABC, 2'd3, 1, 0, 0));
    ex.push_back(e_enter(32'h1C00_0040, 32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(s(1, 1, 32'h8000_2000, 32'h1234_5678, 2'd1, 0, 0, 0));
    ex.push_back(e_enter(32'h1C00_0040, 32'h8000_2001, 32'h1234_5678, 19'h091A2, 3'b001));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_2001, 32'h1234_5678, 19'h091A2, 3'b001));
    st.push_back(s(0, 1, 32'h0, 32'h0, 2'd0, 0, 0, 0));
    ex.push_back(e_leave(32'h8000_2001, 32'h1234_5678, 19'h091A2, 3'b001));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_2000, 32'h1234_5678, 19'h091A2, 3'b001));
    run_table("simultaneous", st, ex);
  endtask

  task automatic test_ignore_in_enter_leave();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(s(1, 0, 32'h8000_3000, 32'h0000_4000, 2'd2, 0, 0, 0));
    ex.push_back(e_enter(32'h1C00_0040, 32'h8000_3001, 32'h0000_4000, 19'h00002, 3'b010));
    st.push_back(s(1, 1, 32'h8000_5000, 32'hFFFF_FFFF, 2'd3, 1, 0, 0));
    ex.push_back(e_idle(32'h8000_3001, 32'h0000_4000, 19'h00002, 3'b010));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_3001, 32'h0000_4000, 19'h00002, 3'b010));
    st.push_back(s(0, 1, 32'h0, 32'h0, 2'd0, 0, 0, 0));
    ex.push_back(e_leave(32'h8000_3001, 32'h0000_4000, 19'h00002, 3'b010));
    st.push_back(s(1, 0, 32'h8000_6000, 32'h5555_5555, 2'd1, 1, 1, 32'h1111_1111));
    ex.push_back(e_idle(32'h8000_3000, 32'h0000_4000, 19'h00002, 3'b010));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_3000, 32'h0000_4000, 19'h00002, 3'b010));
    run_table("ignore_enter_leave", st, ex);
  endtask

  task automatic test_sw_era_write();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(s(1, 0, 32'h8000_1234, 32'h0040_2ABC, 2'd3, 1, 1, 32'h5555_5555));
    ex.push_back(e_enter(32'h1C00_0040, 32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h8000_1235, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(s(0, 0, 32'h0, 32'h0, 2'd0, 0, 1, 32'h9000_0003));
    ex.push_back(e_idle(32'h9000_0001, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(s(0, 1, 32'h0, 32'h0, 2'd0, 0, 0, 0));
    ex.push_back(e_leave(32'h9000_0001, 32'h0040_2ABC, 19'h00201, 3'b111));
    st.push_back(idle_s());
    ex.push_back(e_idle(32'h9000_0000, 32'h0040_2ABC, 19'h00201, 3'b111));
    run_table("sw_era_write", st, ex);
  endtask

  task automatic test_entry_sampling();
    stim_t st[$];
    exp_t  ex[$];
    @(negedge clk);
    TLBRENTRY = 32'h2000_0000;
    apply(s(1, 0, 32'h8000_7000, 32'h0000_2000, 2'd1, 1, 0, 0));
    @(negedge clk);
    apply(idle_s());
    TLBRENTRY = 32'h3000_00BF;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000_0080) begin
      errors++;
      $display("FAIL entry_sampling got valid=%b pc=%h want valid=1 pc=30000080",
               redirect_valid, redirect_pc);
    end
    st.push_back(s(0, 1, 32'h0, 32'h0, 2'd0, 0, 0, 0));
    ex.push_back(e_leave(32'h8000_7001, 32'h0000_2000, 19'h00001, 3'b101));
    run_table("entry_return", st, ex);
    TLBRENTRY = 32'h1C00_0040;
  endtask

  task automatic test_reset_mid_enter();
    exp_t o;
    @(negedge clk);
    apply(s(1, 0, 32'h8000_8000, 32'hABCD_E000, 2'd3, 1, 0, 0));
    @(negedge clk);
    apply(idle_s());
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_enter got flush=%b want 1", flush);
    end
    rst_n = 1'b0;
    #1;
    o = snap(); checks++;
    if (o !== e_idle(32'h0, 32'h0, 19'h0, 3'h0)) begin
      errors++;
      $display("FAIL reset_mid_enter got %h want %h", o, e_idle(32'h0, 32'h0, 19'h0, 3'h0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    o = snap(); checks++;
    if (o !== e_idle(32'h0, 32'h0, 19'h0, 3'h0)) begin
      errors++;
      $display("FAIL after_reset got %h want %h", o, e_idle(32'h0, 32'h0, 19'h0, 3'h0));
    end
  endtask

  initial begin
    test_reset();
    test_basic_refill();
    test_return();
    test_stray_ertn();
    test_simultaneous();
    test_ignore_in_enter_leave();
    test_sw_era_write();
    test_entry_sampling();
    test_reset_mid_enter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
